dtree_feature_loader: RTL and testbench



---
 rtl/dtree_pkg.sv | 30 +++
 rtl/dtree_feature_loader_if.sv | 33 +++
 rtl/dtree_feature_loader.sv | 141 ++++++++++++++
 tb/tb_dtree_feature_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// dtree_pkg: shared constants and types for the decision-tree feature loader.
// Holds the frame geometry (NUM_FEATURES, NUM_SEL, CLASS_W), the ascending
// table of raw feature indices the tree consumes (SEL_IDX) and the loader
// state encoding.
// Optional feature macro: FRAME_CHECK_EN (adds the DRAIN state).
package dtree_pkg;

  localparam int NUM_FEATURES = 279;
  localparam int NUM_SEL      = 45;
  localparam int CLASS_W      = 5;

  // Raw frame positions captured into slots 0..NUM_SEL-1, strictly ascending.
  localparam logic [8:0] SEL_IDX [NUM_SEL] = '{
    9'd0,   9'd2,   9'd5,   9'd9,   9'd10,  9'd12,  9'd13,  9'd50,  9'd55,
    9'd74,  9'd91,  9'd124, 9'd139, 9'd147, 9'd164, 9'd170, 9'd171, 9'd175,
    9'd180, 9'd184, 9'd186, 9'd190, 9'd195, 9'd199, 9'd205, 9'd209, 9'd216,
    9'd221, 9'd222, 9'd235, 9'd236, 9'd240, 9'd246, 9'd251, 9'd255, 9'd256,
    9'd257, 9'd258, 9'd261, 9'd264, 9'd265, 9'd271, 9'd274, 9'd275, 9'd276
  };

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EVAL    = 2'd1,
    ST_HOLD    = 2'd2
`ifdef FRAME_CHECK_EN
    , ST_DRAIN = 2'd3
`endif
  } state_e;

endpackage

// File: rtl/dtree_feature_loader_if.sv
// dtree_feature_loader_if: bundles the byte stream, the tree-facing feature
// bank/class pair and the result stream of the feature loader.
//   s_valid/s_ready/s_data/s_last : byte-serial frame input
//   feat_vec / tree_class         : captured features out, tree class back
//   m_valid/m_ready/m_class       : registered result stream
//   frame_err                     : one-cycle malformed-frame pulse
// modport slave  : the loader itself
// modport master : the surrounding system (byte source, tree, consumer)
interface dtree_feature_loader_if;
  import dtree_pkg::*;

  logic                   s_valid;
  logic                   s_ready;
  logic [7:0]             s_data;
  logic                   s_last;
  logic [NUM_SEL*8-1:0]   feat_vec;
  logic [CLASS_W-1:0]     tree_class;
  logic                   m_valid;
  logic                   m_ready;
  logic [CLASS_W-1:0]     m_class;
  logic                   frame_err;

  modport slave (
    input  s_valid, s_data, s_last, tree_class, m_ready,
    output s_ready, feat_vec, m_valid, m_class, frame_err
  );

  modport master (
    output s_valid, s_data, s_last, tree_class, m_ready,
    input  s_ready, feat_vec, m_valid, m_class, frame_err
  );

endinterface

// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader: accepts one byte-serial frame of NUM_FEATURES raw
// features, keeps only the SEL_IDX positions in a parallel register bank
// (feat_vec), waits one cycle for the external combinational tree to settle,
// registers its class and offers it on a valid/ready result port.
// Ports: clk, rst_n (async, active-low) and the interface modport bus.slave
// (stream in, feature bank/tree class, result out, frame_err).
// Optional feature macro: FRAME_CHECK_EN -- checks s_last against the frame
// length, pulses frame_err on a mismatch and drains over-long frames.
module dtree_feature_loader
  import dtree_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  dtree_feature_loader_if.slave  bus
);

  localparam logic [8:0] LAST_IDX = 9'(NUM_FEATURES - 1);
  localparam logic [5:0] SEL_END  = 6'(NUM_SEL);

  state_e                 state_q;
  logic [8:0]             idx_q;
  logic [5:0]             sel_ptr_q;
  logic [NUM_SEL*8-1:0]   feat_q;
  logic [CLASS_W-1:0]     m_class_q;
  logic                   m_valid_q;
  logic                   s_ready_q;
  logic                   xfer;
  logic                   sel_hit;

  assign xfer    = bus.s_valid && s_ready_q;
  // sel_ptr is range-checked first so the table lookup is only meaningful in range.
  assign sel_hit = (sel_ptr_q < SEL_END) && (idx_q == SEL_IDX[sel_ptr_q]);

  assign bus.s_ready  = s_ready_q;
  assign bus.feat_vec = feat_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_class  = m_class_q;

`ifdef FRAME_CHECK_EN
  logic frame_err_q;
  assign bus.frame_err = frame_err_q;
`else
  // s_last carries no meaning when frames are delimited by count alone.
  logic unused_s_last;
  assign unused_s_last = bus.s_last;
  assign bus.frame_err = 1'b0;
`endif

  // Loader FSM: byte capture, class registration and result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      idx_q       <= 9'd0;
      sel_ptr_q   <= 6'd0;
      feat_q      <= '0;
      m_class_q   <= '0;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b1;
`ifdef FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
`ifdef FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
      case (state_q)
        ST_COLLECT: begin
          if (xfer) begin
            if (sel_hit) begin
              for (int k = 0; k < NUM_SEL; k++) begin
                if (sel_ptr_q == 6'(k)) begin
                  feat_q[k*8 +: 8] <= bus.s_data;
                end
              end
              sel_ptr_q <= sel_ptr_q + 6'd1;
            end
            if (idx_q == LAST_IDX) begin
`ifdef FRAME_CHECK_EN
              if (bus.s_last) begin
                state_q   <= ST_EVAL;
                s_ready_q <= 1'b0;
              end else begin
                state_q   <= ST_DRAIN;
              end
`else
              state_q   <= ST_EVAL;
              s_ready_q <= 1'b0;
`endif
            end else begin
`ifdef FRAME_CHECK_EN
              // Early s_last: these clears override the capture increment above.
              if (bus.s_last) begin
                frame_err_q <= 1'b1;
                idx_q       <= 9'd0;
                sel_ptr_q   <= 6'd0;
              end else begin
                idx_q <= idx_q + 9'd1;
              end
`else
              idx_q <= idx_q + 9'd1;
`endif
            end
          end
        end
        ST_EVAL: begin
          // feat_vec has been stable for a full cycle, so tree_class is settled.
          m_class_q <= bus.tree_class;
          m_valid_q <= 1'b1;
          state_q   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            idx_q     <= 9'd0;
            sel_ptr_q <= 6'd0;
            s_ready_q <= 1'b1;
            state_q   <= ST_COLLECT;
          end
        end
`ifdef FRAME_CHECK_EN
        ST_DRAIN: begin
          if (xfer && bus.s_last) begin
            frame_err_q <= 1'b1;
            idx_q       <= 9'd0;
            sel_ptr_q   <= 6'd0;
            state_q     <= ST_COLLECT;
          end
        end
`endif
        default: begin
          state_q   <= ST_COLLECT;
          idx_q     <= 9'd0;
          sel_ptr_q <= 6'd0;
          m_valid_q <= 1'b0;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// tb_dtree_feature_loader: scoreboard bench for dtree_feature_loader.
// A small tree stub derives the class from slot 22 so the registered class
// depends on the captured features. Expected class/feature bank per frame is
// pushed when the frame is driven and popped at each result handshake.
// Works with and without FRAME_CHECK_EN defined.
module tb_dtree_feature_loader;
  import dtree_pkg::*;

  localparam int FW = NUM_SEL * 8;
  localparam int TB_SEL [45] = '{
    0, 2, 5, 9, 10, 12, 13, 50, 55, 74, 91, 124, 139, 147, 164, 170, 171, 175,
    180, 184, 186, 190, 195, 199, 205, 209, 216, 221, 222, 235, 236, 240, 246,
    251, 255, 256, 257, 258, 261, 264, 265, 271, 274, 275, 276
  };

  typedef struct {
    logic [4:0]    cls;
    logic [FW-1:0] feat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;
  int   ferr_pulses;
  int   ferr_cycles;
  logic ferr_prev;
  exp_t sb_q [$];

  dtree_feature_loader_if bus ();

  dtree_feature_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Tree stub: class 13 for the ramp frame (slot 22 = 0xC3).
  assign bus.tree_class = bus.feat_vec[22*8 +: 5] ^ 5'h0E;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input bit xp);
    logic [7:0] b;
    b = 8'(i);
    return xp ? (b ^ 8'h5A) : b;
  endfunction

  function automatic logic [FW-1:0] exp_feat(input bit xp);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_SEL; k++) f[k*8 +: 8] = pat(TB_SEL[k], xp);
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit last, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.s_ready) begin
      @(posedge clk);
      ok = 1'b1;
    end
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input bit xp, input int nbytes, input int last_at,
                            input int bubble_pct, input bit expect_result);
    bit   ok;
    exp_t e;
    for (int i = 0; i < nbytes; i++) begin
      for (int b = 0; b < 4 && int'($urandom_range(99)) < bubble_pct; b++) @(negedge clk);
      send_byte(pat(i, xp), i == last_at, ok);
      if (!ok) begin
        chk("s_ready_timeout", 1'b0, 1'b1);
        return;
      end
    end
    if (expect_result) begin
      e.feat = exp_feat(xp);
      e.cls  = e.feat[22*8 +: 5] ^ 5'h0E;
      sb_q.push_back(e);
      chk("mv_not_early", bus.m_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("mv_latency", bus.m_valid, 1'b1);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (bus.s_ready && !bus.m_valid) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 1'b0, 1'b1);
  endtask

  // Result monitor: pop and compare at each pending handshake.
  always @(negedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("m_class", bus.m_class, e.cls);
        chk("feat_vec", bus.feat_vec, e.feat);
        chk("s_ready_in_hold", bus.s_ready, 1'b0);
      end
    end
  end

  // frame_err pulse counter.
  always @(negedge clk) begin
    if (bus.frame_err) ferr_cycles <= ferr_cycles + 1;
    if (bus.frame_err && !ferr_prev) ferr_pulses <= ferr_pulses + 1;
    ferr_prev <= bus.frame_err;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    ferr_pulses  = 0;
    ferr_cycles  = 0;
    ferr_prev    = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = 8'h00;
    bus.s_last   = 1'b0;
    bus.m_ready  = 1'b1;
    rst_n        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 1'b1);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_class", bus.m_class, 5'd0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_feat_vec", bus.feat_vec, '0);
    rst_n = 1'b1;

    // Full ramp frame
    send_frame(1'b0, NUM_FEATURES, NUM_FEATURES - 1, 0, 1'b1);
    chk("slot22", bus.feat_vec[22*8 +: 8], 8'hC3);
    chk("slot0", bus.feat_vec[7:0], 8'h00);
    chk("class13", bus.m_class, 5'd13);
    wait_idle();

    // Backpressure
    bus.m_ready = 1'b0;
    send_frame(1'b0, NUM_FEATURES, NUM_FEATURES - 1, 0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_m_valid", bus.m_valid, 1'b1);
      chk("bp_m_class", bus.m_class, 5'd13);
      chk("bp_s_ready", bus.s_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_s_ready_after", bus.s_ready, 1'b1);
    chk("bp_m_valid_after", bus.m_valid, 1'b0);
    wait_idle();

    // Random input bubbles
    send_frame(1'b0, NUM_FEATURES, NUM_FEATURES - 1, 30, 1'b1);
    wait_idle();

    // Short frame (s_last on byte 100)
`ifdef FRAME_CHECK_EN
    send_frame(1'b1, 101, 100, 0, 1'b0);
    chk("ferr_pulse", bus.frame_err, 1'b1);
    chk("short_no_result", bus.m_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("ferr_width", bus.frame_err, 1'b0);
    chk("short_s_ready", bus.s_ready, 1'b1);
    send_frame(1'b0, NUM_FEATURES, NUM_FEATURES - 1, 0, 1'b1);
    wait_idle();
`else
    send_frame(1'b1, NUM_FEATURES, 100, 0, 1'b1);
    chk("short_no_err", bus.frame_err, 1'b0);
    wait_idle();
`endif

    // Reset in the middle of a frame
    send_frame(1'b0, 151, -1, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_feat_vec", bus.feat_vec, '0);
    chk("midrst_s_ready", bus.s_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b0, NUM_FEATURES, NUM_FEATURES - 1, 0, 1'b1);
    chk("midrst_class", bus.m_class, 5'd13);
    wait_idle();

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
`ifdef FRAME_CHECK_EN
    chk("ferr_pulses", ferr_pulses, 1);
`else
    chk("ferr_pulses", ferr_pulses, 0);
`endif
    chk("ferr_cycles", ferr_cycles, ferr_pulses);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
